// File: rtl/nn_share_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_share_pkg
// Brief    : Shared types and width helpers for the shared-layer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package nn_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Counter width for a modulo-depth counter; never narrower than one bit.
    function automatic int cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Combinational two-way round-robin picker; a tie goes to ~last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       any
);

    always_comb begin
        any     = |req;
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/nn_layer_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nn_layer_share_arbiter
// Brief    : Time-shares one streaming FC layer between two requesters, one
//            job (N beats in, M beats out) per grant, round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module nn_layer_share_arbiter
    import nn_share_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 6,
    parameter int M  = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*W-1:0]  req_data,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [W-1:0]    rsp_data,
    output logic            lyr_s_valid,
    input  logic            lyr_s_ready,
    output logic [W-1:0]    lyr_data_in,
    input  logic            lyr_m_valid,
    output logic            lyr_m_ready,
    input  logic [W-1:0]    lyr_data_out,
    output logic            grant,
    output logic            busy,
    output logic [2*CW-1:0] jobs_done,
    output logic            proto_err
);

    localparam int                 c_IN_W    = cnt_w(N);
    localparam int                 c_OUT_W   = cnt_w(M);
    localparam logic [c_IN_W-1:0]  c_IN_LAST = c_IN_W'(N - 1);
    localparam logic [c_IN_W-1:0]  c_IN_ONE  = c_IN_W'(1);
    localparam logic [c_OUT_W-1:0] c_OUT_LAST = c_OUT_W'(M - 1);
    localparam logic [c_OUT_W-1:0] c_OUT_ONE  = c_OUT_W'(1);
    localparam logic [CW-1:0]      c_JOB_ONE  = CW'(1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_grant;
    logic                   r_last_grant;
    logic [c_IN_W-1:0]      r_in_cnt;
    logic [c_OUT_W-1:0]     r_out_cnt;
    logic [1:0][CW-1:0]     r_jobs_done;
    logic                   r_proto_err;
    logic                   w_pick_idx;
    logic                   w_pick_any;
    logic                   w_in_fire;
    logic                   w_out_fire;

    rr_pick2 u_pick (
        .req     (req_valid),
        .last    (r_last_grant),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    always_comb begin
        w_next_state = r_state;
        w_in_fire    = 1'b0;
        w_out_fire   = 1'b0;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        lyr_s_valid  = 1'b0;
        lyr_m_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                lyr_s_valid        = req_valid[r_grant];
                req_ready[r_grant] = lyr_s_ready;
                w_in_fire          = req_valid[r_grant] & lyr_s_ready;
                if (w_in_fire && (r_in_cnt == c_IN_LAST)) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                rsp_valid[r_grant] = lyr_m_valid;
                lyr_m_ready        = rsp_ready[r_grant];
                w_out_fire         = lyr_m_valid & rsp_ready[r_grant];
                if (w_out_fire && (r_out_cnt == c_OUT_LAST)) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Data words pass straight through; only the handshakes are steered.
    assign lyr_data_in = r_grant ? req_data[2*W-1:W] : req_data[W-1:0];
    assign rsp_data    = lyr_data_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_jobs_done  <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && w_pick_any) r_grant <= w_pick_idx;
            if (w_in_fire) begin
                r_in_cnt <= (r_in_cnt == c_IN_LAST) ? '0 : r_in_cnt + c_IN_ONE;
            end
            if (w_out_fire) begin
                if (r_out_cnt == c_OUT_LAST) begin
                    r_out_cnt             <= '0;
                    r_last_grant          <= r_grant;
                    r_jobs_done[r_grant]  <= r_jobs_done[r_grant] + c_JOB_ONE;
                end else begin
                    r_out_cnt <= r_out_cnt + c_OUT_ONE;
                end
            end
            // Layer output while no job is draining means the layer lost sync.
            if (lyr_m_valid && (r_state != ST_DRAIN)) r_proto_err <= 1'b1;
        end
    end

    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign jobs_done = r_jobs_done;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_layer_share_arbiter
// Brief    : Self-checking bench: random jobs from two requesters through a
//            behavioural layer, per-requester output streams vs. expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_layer_share_arbiter;

    localparam int W  = 16;
    localparam int N  = 6;
    localparam int M  = 8;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*W-1:0]  req_data = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = '0;
    logic [W-1:0]    rsp_data;
    logic            lyr_s_valid;
    logic            lyr_s_ready = 1'b0;
    logic [W-1:0]    lyr_data_in;
    logic            lyr_m_valid = 1'b0;
    logic            lyr_m_ready;
    logic [W-1:0]    lyr_data_out = '0;
    logic            grant;
    logic            busy;
    logic [2*CW-1:0] jobs_done;
    logic            proto_err;

    always #5 clk = ~clk;

    nn_layer_share_arbiter #(.W(W), .N(N), .M(M), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .lyr_s_valid  (lyr_s_valid),
        .lyr_s_ready  (lyr_s_ready),
        .lyr_data_in  (lyr_data_in),
        .lyr_m_valid  (lyr_m_valid),
        .lyr_m_ready  (lyr_m_ready),
        .lyr_data_out (lyr_data_out),
        .grant        (grant),
        .busy         (busy),
        .jobs_done    (jobs_done),
        .proto_err    (proto_err)
    );

    bit gaps_en, sready_rand, mvalid_rand, rready_rand, sready_off, force_mv;
    int n_assert = 0;
    int n_fail   = 0;
    int viol     = 0;

    logic [W-1:0]  rq    [2][$];
    logic [W-1:0]  exp_q [2][$];
    logic [W-1:0]  got_q [2][$];
    logic [W-1:0]  lm_in [$];
    logic [W-1:0]  lm_out[$];
    logic          gseq  [$];
    int            in_hs [2];
    logic [CW-1:0] model_jobs [2];
    bit            final_seen, prev_busy, env_own;

    // Behavioural layer: output k of a job depends only on that job's inputs.
    function automatic logic [W-1:0] lyr_fn(input logic [W-1:0] words[$], input int k);
        return words[k % N] ^ W'((k + 1) * 257);
    endfunction

    // Environment: sample handshakes on the falling edge, drive after the rising edge.
    always begin
        @(negedge clk);
        if (reset) begin
            lm_in.delete();
            lm_out.delete();
            model_jobs[0] = '0;
            model_jobs[1] = '0;
            final_seen    = 1'b0;
            prev_busy     = 1'b0;
        end else begin
            if (jobs_done !== {model_jobs[1], model_jobs[0]}) viol++;
            if (final_seen && busy) viol++;
            final_seen = 1'b0;
            if (busy && !prev_busy) gseq.push_back(grant);
            prev_busy = busy;
            if (lyr_m_ready && !busy) viol++;
            for (int i = 0; i < 2; i++) begin
                env_own = busy && (grant == i[0]);
                if ((req_ready[i] || rsp_valid[i]) && !env_own) viol++;
                if (req_valid[i] && req_ready[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    in_hs[i]++;
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    got_q[i].push_back(rsp_data);
                    if (got_q[i].size() % M == 0) begin
                        model_jobs[i] = model_jobs[i] + 1'b1;
                        final_seen    = 1'b1;
                    end
                end
            end
            if (lyr_s_valid && lyr_s_ready) begin
                lm_in.push_back(lyr_data_in);
                if (lm_in.size() == N) begin
                    for (int k = 0; k < M; k++) lm_out.push_back(lyr_fn(lm_in, k));
                    lm_in.delete();
                end
            end
            if (lyr_m_valid && lyr_m_ready && lm_out.size() > 0) void'(lm_out.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]     = (rq[i].size() > 0) && !(gaps_en && ($urandom_range(0, 3) == 0));
            req_data[i*W +: W] = (rq[i].size() > 0) ? rq[i][0] : W'($urandom);
            rsp_ready[i]     = !rready_rand || ($urandom_range(0, 2) != 0);
        end
        lyr_s_ready  = !sready_off && (lm_out.size() == 0) &&
                       (!sready_rand || ($urandom_range(0, 1) == 1));
        lyr_m_valid  = force_mv || ((lm_out.size() > 0) && (!mvalid_rand || ($urandom_range(0, 2) != 0)));
        lyr_data_out = (lm_out.size() > 0) ? lm_out[0] : W'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic enqueue_job(input int r);
        logic [W-1:0] w[$];
        for (int j = 0; j < N; j++) begin
            w.push_back(W'($urandom));
            rq[r].push_back(w[j]);
        end
        for (int k = 0; k < M; k++) exp_q[r].push_back(lyr_fn(w, k));
    endtask

    task automatic clear_all();
        for (int i = 0; i < 2; i++) begin
            rq[i].delete();
            exp_q[i].delete();
            got_q[i].delete();
            in_hs[i] = 0;
        end
        gseq.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sync();
        clear_all();
        sync();
        reset = 1'b0;
    endtask

    task automatic wait_drained(input int limit, input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            sync();
            if (rq[0].size() == 0 && rq[1].size() == 0 && !busy &&
                got_q[0].size() == exp_q[0].size() && got_q[1].size() == exp_q[1].size()) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, " drained"}, 64'(ok), 64'd1);
    endtask

    task automatic check_streams(input string tag);
        for (int i = 0; i < 2; i++) begin
            int bad = 0;
            chk($sformatf("%s len%0d", tag, i), 64'(got_q[i].size()), 64'(exp_q[i].size()));
            for (int k = 0; k < got_q[i].size() && k < exp_q[i].size(); k++)
                if (got_q[i][k] !== exp_q[i][k]) bad++;
            chk($sformatf("%s data%0d", tag, i), 64'(bad), 64'd0);
        end
        chk({tag, " protocol"}, 64'(viol), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1;
        clear_all();
        repeat (3) sync();
        chk("rst busy",      64'(busy),        64'd0);
        chk("rst grant",     64'(grant),       64'd0);
        chk("rst jobs",      64'(jobs_done),   64'd0);
        chk("rst proto",     64'(proto_err),   64'd0);
        chk("rst req_ready", 64'(req_ready),   64'd0);
        chk("rst rsp_valid", 64'(rsp_valid),   64'd0);
        chk("rst s_valid",   64'(lyr_s_valid), 64'd0);
        chk("rst m_ready",   64'(lyr_m_ready), 64'd0);
        reset = 1'b0;

        // Single job on requester 0
        enqueue_job(0);
        wait_drained(200, "p1");
        chk("p1 in beats", 64'(in_hs[0]), 64'(N));
        chk("p1 in beats1", 64'(in_hs[1]), 64'd0);
        chk("p1 jobs", 64'(jobs_done), {48'd0, 8'd0, 8'd1});
        chk("p1 grants", 64'(gseq.size()), 64'd1);
        if (gseq.size() > 0) chk("p1 grant0", 64'(gseq[0]), 64'd0);
        check_streams("p1");

        // Both requesters continuously valid: grants alternate
        do_reset();
        enqueue_job(0); enqueue_job(0);
        enqueue_job(1); enqueue_job(1);
        wait_drained(400, "p2");
        chk("p2 grants", 64'(gseq.size()), 64'd4);
        for (int k = 0; k < gseq.size() && k < 4; k++)
            chk($sformatf("p2 grant%0d", k), 64'(gseq[k]), 64'(k % 2));
        chk("p2 jobs", 64'(jobs_done), {48'd0, 8'd2, 8'd2});
        check_streams("p2");

        // Random backpressure and valid gaps on every interface
        gaps_en = 1; sready_rand = 1; mvalid_rand = 1; rready_rand = 1;
        n0 = $urandom_range(2, 4);
        n1 = $urandom_range(2, 4);
        for (int j = 0; j < 4; j++) begin
            if (j < n0) enqueue_job(0);
            if (j < n1) enqueue_job(1);
        end
        wait_drained(3000, "p3");
        chk("p3 jobs", 64'(jobs_done), {48'd0, 8'(2 + n1), 8'(2 + n0)});
        check_streams("p3");
        gaps_en = 0; sready_rand = 0; mvalid_rand = 0; rready_rand = 0;

        // Reset part-way through loading a job
        do_reset();
        enqueue_job(1);
        for (int c = 0; c < 100 && in_hs[1] < 3; c++) sync();
        chk("p4 partial", 64'(in_hs[1] >= 3), 64'd1);
        reset = 1'b1;
        sync();
        chk("p4 busy", 64'(busy), 64'd0);
        chk("p4 grant", 64'(grant), 64'd0);
        chk("p4 jobs", 64'(jobs_done), 64'd0);
        clear_all();
        sync();
        reset = 1'b0;
        enqueue_job(0);
        enqueue_job(1);
        wait_drained(400, "p4");
        chk("p4 grants", 64'(gseq.size()), 64'd2);
        if (gseq.size() > 0) chk("p4 first grant", 64'(gseq[0]), 64'd0);
        chk("p4 jobs after", 64'(jobs_done), {48'd0, 8'd1, 8'd1});
        check_streams("p4");

        // Layer output appearing during LOAD
        in_hs[0] = 0;
        enqueue_job(0);
        for (int c = 0; c < 100 && in_hs[0] < 2; c++) sync();
        sready_off = 1;
        sync();
        sync();
        force_mv = 1;
        sync();
        sync();
        chk("p5 m_valid", 64'(lyr_m_valid), 64'd1);
        chk("p5 m_ready", 64'(lyr_m_ready), 64'd0);
        chk("p5 busy", 64'(busy), 64'd1);
        force_mv = 0;
        sync();
        chk("p5 proto set", 64'(proto_err), 64'd1);
        sready_off = 0;
        enqueue_job(1);
        enqueue_job(0);
        wait_drained(600, "p5");
        chk("p5 proto sticky", 64'(proto_err), 64'd1);
        check_streams("p5");
        do_reset();
        chk("p5 proto cleared", 64'(proto_err), 64'd0);

        // Completed-job counter wrap
        for (int j = 0; j < 255; j++) enqueue_job(0);
        wait_drained(255 * 20, "p6a");
        chk("p6 jobs 255", 64'(jobs_done), {48'd0, 8'd0, 8'd255});
        enqueue_job(0);
        wait_drained(100, "p6b");
        chk("p6 jobs wrap", 64'(jobs_done), 64'd0);
        check_streams("p6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nn_layer_share_arbiter.md
Name: nn_layer_share_arbiter

Overview:
Shares one streaming fully-connected layer instance (ready/valid in, ready/valid out, N inputs -> M outputs per job) between two independent requesters. It grants one requester per job with round-robin priority. It forwards that requester's N input beats to the layer, then routes the layer's M output beats back to the same requester. It sits between two upstream network pipelines and a single time-multiplexed MVMA layer.

Parameters:
W, 16, data word width (signed)
N, 6, input words per job (layer fan-in)
M, 8, output words per job (layer fan-out)
CW, 8, width of per-requester completed-job counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-requester input beat valid
req_ready  out  2  per-requester input beat accepted
req_data  in  2xW  per-requester input words (signed)
rsp_valid  out  2  per-requester output beat valid
rsp_ready  in  2  per-requester output beat consumed
rsp_data  out  W  output word; valid only for the lane whose rsp_valid is high
lyr_s_valid  out  1  to layer s_valid
lyr_s_ready  in  1  from layer s_ready
lyr_data_in  out  W  to layer data_in
lyr_m_valid  in  1  from layer m_valid
lyr_m_ready  out  1  to layer m_ready
lyr_data_out  in  W  from layer data_out
grant  out  1  index of the owning requester; meaningful when busy=1
busy  out  1  high in LOAD or DRAIN
jobs_done  out  2xCW  per-requester completed-job counters, wrapping
proto_err  out  1  sticky: layer produced output outside DRAIN

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=IDLE; in_cnt=0, out_cnt=0; last_grant=1, so requester 0 wins the first tie.
  - Outputs: jobs_done=0, proto_err=0, grant=0, busy=0, and all valid/ready outputs 0.
- Reset mid-job abandons the job with no flush. The layer must be reset in the same cycle by the integrator.
- FSM:
  - IDLE:
    - If no req_valid, stay.
    - If exactly one req_valid, grant it.
    - If both, grant ~last_grant.
    - Register grant, go to LOAD next cycle. No beat is accepted in IDLE.
  - LOAD (granted requester g):
    - Combinational pass-through: lyr_s_valid=req_valid[g], lyr_data_in=req_data[g], req_ready[g]=lyr_s_ready.
    - req_ready of the other requester is 0.
    - in_cnt increments on each lyr_s_valid&&lyr_s_ready.
    - On the accept where in_cnt==N-1, set in_cnt=0 and go to DRAIN.
  - DRAIN:
    - rsp_valid[g]=lyr_m_valid, rsp_data=lyr_data_out, lyr_m_ready=rsp_ready[g].
    - The other requester's rsp_valid is 0.
    - out_cnt increments on each lyr_m_valid&&lyr_m_ready.
    - On the handshake where out_cnt==M-1: out_cnt=0, last_grant=g, jobs_done[g]+=1, go to IDLE.
- Zero added latency on the data path; only the IDLE->LOAD grant costs one cycle. Back-to-back jobs have a 1-cycle IDLE bubble.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- A requester that drops req_valid during LOAD stalls the job; grant is not revoked.
- lyr_m_ready=0 outside DRAIN. If lyr_m_valid=1 outside DRAIN, set proto_err=1; only reset clears it.
- jobs_done wraps from 2^CW-1 to 0.
- No arithmetic on data; words pass bit-exact.

Decomposition:
- Package nn_share_pkg:
  - state enum {IDLE, LOAD, DRAIN} (2-bit).
  - Localparam helpers for counter widths: $clog2(N), $clog2(M).
- One sub-module: rr_pick2.
  - Combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_idx, any.

Test Plan:
1. Only req 0 valid, N=6 words 1..6, layer echoes eight outputs 10..17 -> req_ready[0] high for exactly 6 handshakes; rsp_valid[0] delivers 10..17 in order; rsp_valid[1] never high; jobs_done[0]=1; busy falls one cycle after the 8th output.
2. Both requesters valid continuously for 4 jobs -> grant sequence 0,1,0,1; jobs_done={2,2}; req 1 sees no req_ready until job 0's 8th output completes.
3. Backpressure: lyr_s_ready toggles every other cycle in LOAD, rsp_ready held 0 for 5 cycles mid-DRAIN -> no beat lost or duplicated; counts stay 6 in / 8 out.
4. Reset asserted after 3 inputs of a job -> next cycle state IDLE, busy=0, in_cnt=0; next job restarts from beat 1 with grant to requester 0.
5. lyr_m_valid pulsed high during LOAD -> proto_err=1 and stays 1 through later jobs until reset; lyr_m_ready stays 0.
6. Run 256 jobs on req 0 with CW=8 -> jobs_done[0] wraps to 0.
